// File: rtl/mskaes_32bits_key_sched_multi.sv
// Masked AES key schedule: emits round-key words one shared 32-bit column at a time via a shared Sbox port.
// Optional feature macro MSKAES_KS_MULTISIZE_EN enables AES-192/256 (8-word store); default is AES-128 only.
module mskaes_32bits_key_sched_multi #(
  parameter int unsigned d      = 2,
  parameter int unsigned SB_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        key_size,
  input  logic [256*d-1:0]  sh_key,
  output logic [32*d-1:0]   sh_sb_out,
  output logic              sb_req,
  input  logic [32*d-1:0]   sh_sb_in,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic [32*d-1:0]   sh_rk,
  output logic [5:0]        rk_idx,
  output logic              rk_last
);

  localparam int unsigned WW = 32 * d;
`ifdef MSKAES_KS_MULTISIZE_EN
  localparam int unsigned NS = 8;
`else
  localparam int unsigned NS = 4;
`endif
  localparam int unsigned IW = $clog2(NS);
  localparam int unsigned CW = $clog2(SB_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_SB_WAIT} state_e;

  state_e                 state_q, state_d;
  logic [NS-1:0][WW-1:0]  st_q, st_d;
  logic [WW-1:0]          rk_q, rk_d, sb_out_q, sb_out_d;
  logic [5:0]             idx_q, idx_d;
  logic [2:0]             pos_q, pos_d;
  logic [3:0]             nk_q, nk_d;
  logic [7:0]             rcon_q, rcon_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   rot_q, rot_d;
  logic                   in_ready_q, in_ready_d, rk_valid_q, rk_valid_d;
  logic                   sb_req_q, sb_req_d, rk_last_q, rk_last_d;

  logic [3:0]             nk_load_c;
  logic [5:0]             nw_c, idx_nx_c;
  logic [2:0]             pos_nx_c;
  logic [WW-1:0]          w_prev_c, w_old_c, new_c;
  logic                   shift_c;

`ifdef MSKAES_KS_MULTISIZE_EN
  always_comb begin
    case (key_size)
      2'd1:    nk_load_c = 4'd6;
      2'd2:    nk_load_c = 4'd8;
      default: nk_load_c = 4'd4;
    endcase
  end
`else
  logic unused_cfg;
  assign nk_load_c  = 4'd4;
  assign unused_cfg = ^{key_size, sh_key[256*d-1:128*d]};
`endif

  // RotWord applied independently to every share
  function automatic logic [WW-1:0] rot_shares(input logic [WW-1:0] x);
    logic [WW-1:0] y;
    y = '0;
    for (int s = 0; s < int'(d); s++) y[s*32 +: 32] = {x[s*32 +: 24], x[s*32+24 +: 8]};
    return y;
  endfunction

  // Store holds w[i-Nk+1..i] once i >= Nk-1; before that it still holds the raw key
  assign nw_c     = (nk_q == 4'd6) ? 6'd52 : (nk_q == 4'd8) ? 6'd60 : 6'd44;
  assign idx_nx_c = idx_q + 6'd1;
  assign pos_nx_c = (pos_q == 3'(nk_q - 4'd1)) ? 3'd0 : pos_q + 3'd1;
  assign w_prev_c = st_q[IW'(nk_q - 4'd1)];
  assign w_old_c  = st_q[0];

  always_comb begin
    state_d    = state_q;
    st_d       = st_q;
    rk_d       = rk_q;
    sb_out_d   = sb_out_q;
    idx_d      = idx_q;
    pos_d      = pos_q;
    nk_d       = nk_q;
    rcon_d     = rcon_q;
    cnt_d      = cnt_q;
    rot_d      = rot_q;
    in_ready_d = in_ready_q;
    rk_valid_d = rk_valid_q;
    sb_req_d   = 1'b0;
    rk_last_d  = rk_last_q;
    new_c      = '0;
    shift_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          for (int j = 0; j < int'(NS); j++)
            st_d[j] = (4'(j) < nk_load_c) ? sh_key[j*WW +: WW] : '0;
          nk_d       = nk_load_c;
          idx_d      = 6'd0;
          pos_d      = 3'd0;
          rcon_d     = 8'h01;
          rk_d       = sh_key[WW-1:0];
          rk_valid_d = 1'b1;
          in_ready_d = 1'b0;
          rk_last_d  = 1'b0;
          state_d    = S_EMIT;
        end
      end
      S_EMIT: begin
        if (rk_ready) begin
          if (idx_q == nw_c - 6'd1) begin
            rk_valid_d = 1'b0;
            rk_last_d  = 1'b0;
            in_ready_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            idx_d = idx_nx_c;
            pos_d = pos_nx_c;
            if (idx_nx_c < 6'(nk_q)) begin
              rk_d = st_q[IW'(idx_nx_c)];
            end else if (pos_nx_c == 3'd0 || (nk_q == 4'd8 && pos_nx_c == 3'd4)) begin
              rot_d      = (pos_nx_c == 3'd0);
              sb_out_d   = (pos_nx_c == 3'd0) ? rot_shares(w_prev_c) : w_prev_c;
              sb_req_d   = 1'b1;
              cnt_d      = '0;
              rk_valid_d = 1'b0;
              rk_last_d  = 1'b0;
              state_d    = S_SB_WAIT;
            end else begin
              new_c     = w_prev_c ^ w_old_c;
              shift_c   = 1'b1;
              rk_d      = new_c;
              rk_last_d = (idx_nx_c == nw_c - 6'd1);
            end
          end
        end
      end
      S_SB_WAIT: begin
        if (cnt_q == CW'(SB_LAT)) begin
          new_c = sh_sb_in ^ w_old_c;
          if (rot_q) begin
            new_c[31:24] = new_c[31:24] ^ rcon_q;
            rcon_d       = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
          end
          shift_c    = 1'b1;
          rk_d       = new_c;
          rk_valid_d = 1'b1;
          rk_last_d  = (idx_q == nw_c - 6'd1);
          state_d    = S_EMIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (shift_c) begin
      for (int j = 0; j < int'(NS); j++)
        st_d[j] = (4'(j) == nk_q - 4'd1) ? new_c : st_q[IW'((j + 1) % int'(NS))];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      st_q       <= '0;
      rk_q       <= '0;
      sb_out_q   <= '0;
      idx_q      <= '0;
      pos_q      <= '0;
      nk_q       <= '0;
      rcon_q     <= '0;
      cnt_q      <= '0;
      rot_q      <= 1'b0;
      in_ready_q <= 1'b1;
      rk_valid_q <= 1'b0;
      sb_req_q   <= 1'b0;
      rk_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      st_q       <= st_d;
      rk_q       <= rk_d;
      sb_out_q   <= sb_out_d;
      idx_q      <= idx_d;
      pos_q      <= pos_d;
      nk_q       <= nk_d;
      rcon_q     <= rcon_d;
      cnt_q      <= cnt_d;
      rot_q      <= rot_d;
      in_ready_q <= in_ready_d;
      rk_valid_q <= rk_valid_d;
      sb_req_q   <= sb_req_d;
      rk_last_q  <= rk_last_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign rk_valid  = rk_valid_q;
  assign sb_req    = sb_req_q;
  assign sh_sb_out = sb_out_q;
  assign sh_rk     = rk_q;
  assign rk_idx    = idx_q;
  assign rk_last   = rk_last_q;

endmodule

// File: tb/tb_mskaes_32bits_key_sched_multi.sv
// Scoreboard bench for the masked key schedule: FIPS-197 reference expansion plus a masked Sbox model.
module tb_mskaes_32bits_key_sched_multi;
  localparam int unsigned D      = 2;
  localparam int unsigned SB_LAT = 4;
  localparam int unsigned WW     = 32 * D;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       key_size;
  logic [256*D-1:0] sh_key;
  logic [WW-1:0]    sh_sb_out;
  logic             sb_req;
  logic [WW-1:0]    sh_sb_in;
  logic             rk_valid;
  logic             rk_ready;
  logic [WW-1:0]    sh_rk;
  logic [5:0]       rk_idx;
  logic             rk_last;

  mskaes_32bits_key_sched_multi #(.d(D), .SB_LAT(SB_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .key_size(key_size),
    .sh_key(sh_key), .sh_sb_out(sh_sb_out), .sb_req(sb_req), .sh_sb_in(sh_sb_in),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .sh_rk(sh_rk), .rk_idx(rk_idx), .rk_last(rk_last)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] w; logic [5:0] idx; logic last; } exp_t;
  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  int          t_load, t_last;
  logic [31:0] dut_w [60];
  logic [7:0]  sbox_t [256];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  function automatic logic [31:0] rec(input logic [WW-1:0] x);
    logic [31:0] r;
    r = '0;
    for (int s = 0; s < int'(D); s++) r = r ^ x[s*32 +: 32];
    return r;
  endfunction

  function automatic logic [WW-1:0] reshare(input logic [31:0] v);
    logic [WW-1:0] o;
    logic [31:0]   acc, r;
    acc = v; o = '0;
    for (int s = 0; s < int'(D) - 1; s++) begin
      r = $urandom; o[s*32 +: 32] = r; acc = acc ^ r;
    end
    o[(D-1)*32 +: 32] = acc;
    return o;
  endfunction

  function automatic int eff_nk(input logic [1:0] ks);
`ifdef MSKAES_KS_MULTISIZE_EN
    return (ks == 2'd1) ? 6 : (ks == 2'd2) ? 8 : 4;
`else
    return 4;
`endif
  endfunction

  // Masked Sbox: result valid only in the single cycle SB_LAT after the request, junk otherwise
  logic        sb_busy = 1'b0;
  int          sb_due  = 0;
  logic [31:0] sb_res;
  always @(posedge clk) begin
    cyc++;
    if (rst) sb_busy = 1'b0;
    else if (sb_req) begin
      n_checks++;
      if (sb_busy) begin
        n_err++;
        $display("FAIL sbox_overlap: sb_req while a request is outstanding at cycle %0d", cyc);
      end
      sb_busy = 1'b1;
      sb_res  = subw(rec(sh_sb_out));
      sb_due  = cyc + int'(SB_LAT) - 1;
    end
    #1;
    if (sb_busy && cyc == sb_due) begin
      sh_sb_in = reshare(sb_res);
      sb_busy  = 1'b0;
    end else begin
      for (int s = 0; s < int'(D); s++) sh_sb_in[s*32 +: 32] = $urandom;
    end
  end

  task automatic gen_expected(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nw;
    nw = (nk == 4) ? 44 : (nk == 6) ? 52 : 60;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk == 8 && i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < nw; i++) exp_q.push_back('{w: w[i], idx: 6'(i), last: (i == nw - 1)});
  endtask

  task automatic load_key(input logic [255:0] key, input logic [1:0] ks);
    int waited = 0;
    @(posedge clk); #1;
    while (!in_ready && waited < 400) begin
      @(posedge clk); #1; waited++;
    end
    n_checks++;
    if (!in_ready) begin
      n_err++;
      $display("FAIL load_wait: in_ready=%b after %0d cycles, required 1", in_ready, waited);
    end
    gen_expected(key, eff_nk(ks));
    for (int j = 0; j < 8; j++) sh_key[j*WW +: WW] = reshare(key[255 - 32*j -: 32]);
    key_size = ks;
    in_valid = 1'b1;
    @(posedge clk); #1;
    t_load   = cyc;
    in_valid = 1'b0;
    key_size = 2'($urandom);
    n_checks++;
    if (rk_valid !== 1'b1 || rk_idx !== 6'd0 || rec(sh_rk) !== exp_q[0].w) begin
      n_err++;
      $display("FAIL first_word: valid=%b idx=%0d w=%h, required valid=1 idx=0 w=%h",
               rk_valid, rk_idx, rec(sh_rk), exp_q[0].w);
    end
  endtask

  // Pops one expected word per observed handshake; stop_idx allows leaving mid-sequence
  task automatic drain(input bit rnd, input int stop_idx, input int budget);
    int            cycles = 0;
    bit            done = 0, stalled = 0, got_last = 0;
    logic [WW-1:0] h_rk;
    logic [5:0]    h_idx;
    logic          h_last;
    exp_t          e;
    while (!done && cycles < budget) begin
      @(negedge clk); cycles++;
      if (rk_valid && stalled) begin
        n_checks++;
        if (sh_rk !== h_rk || rk_idx !== h_idx || rk_last !== h_last) begin
          n_err++;
          $display("FAIL stall_hold: idx=%0d rk=%h last=%b, held idx=%0d rk=%h last=%b",
                   rk_idx, sh_rk, rk_last, h_idx, h_rk, h_last);
        end
      end
      stalled = 0;
      if (rk_valid && rk_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL extra_word: idx=%0d w=%h with nothing expected", rk_idx, rec(sh_rk));
          done = 1;
        end else begin
          e = exp_q.pop_front();
          if (rec(sh_rk) !== e.w || rk_idx !== e.idx || rk_last !== e.last) begin
            n_err++;
            $display("FAIL word: got w=%h idx=%0d last=%b, required w=%h idx=%0d last=%b",
                     rec(sh_rk), rk_idx, rk_last, e.w, e.idx, e.last);
          end
          dut_w[e.idx] = rec(sh_rk);
          if (e.last) begin t_last = cyc + 1; got_last = 1; end
          if (e.last || int'(e.idx) == stop_idx) done = 1;
        end
      end else if (rk_valid) begin
        stalled = 1; h_rk = sh_rk; h_idx = rk_idx; h_last = rk_last;
      end
      @(posedge clk); #1;
      rk_ready = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
    if (!done) begin
      n_checks++; n_err++;
      $display("FAIL drain_timeout: %0d words still expected after %0d cycles", exp_q.size(), cycles);
    end
    if (got_last) begin
      @(negedge clk);
      n_checks++;
      if (rk_valid !== 1'b0 || rk_last !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL after_last: valid=%b last=%b in_ready=%b, required 0 0 1",
                 rk_valid, rk_last, in_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; rk_ready = 1'b0; key_size = 2'd0; sh_key = '0; sh_sb_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({in_ready, rk_valid, sb_req, rk_last, rk_idx, sh_rk, sh_sb_out} !== {1'b1, 3'b000, 6'd0, {(2*WW){1'b0}}}) begin
      n_err++;
      $display("FAIL reset_values: ready=%b valid=%b req=%b last=%b idx=%0d rk=%h sbo=%h, required 1 0 0 0 0 0 0",
               in_ready, rk_valid, sb_req, rk_last, rk_idx, sh_rk, sh_sb_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_aes128();
    rk_ready = 1'b1;
    load_key(K128, 2'd0);
    drain(0, 99, 600);
    n_checks++;
    if (dut_w[4] !== 32'ha0fafe17) begin
      n_err++; $display("FAIL aes128_w4: got %h required a0fafe17", dut_w[4]);
    end
    n_checks++;
    if (dut_w[43] !== 32'hb6630ca6) begin
      n_err++; $display("FAIL aes128_w43: got %h required b6630ca6", dut_w[43]);
    end
    n_checks++;
    if (t_last - t_load !== 44 + 10 * (int'(SB_LAT) + 1)) begin
      n_err++;
      $display("FAIL aes128_cycles: got %0d required %0d", t_last - t_load, 44 + 10 * (int'(SB_LAT) + 1));
    end
  endtask

  task automatic test_key_size_default();
`ifdef MSKAES_KS_MULTISIZE_EN
    rk_ready = 1'b1;
    load_key(K128, 2'd3);
    drain(0, 99, 600);
    n_checks++;
    if (dut_w[43] !== 32'hb6630ca6) begin
      n_err++; $display("FAIL ks3_w43: got %h required b6630ca6", dut_w[43]);
    end
`else
    rk_ready = 1'b1;
    load_key(K256, 2'd2);
    drain(0, 99, 600);
    n_checks++;
    if (t_last - t_load !== 44 + 10 * (int'(SB_LAT) + 1)) begin
      n_err++;
      $display("FAIL ks_ignored_len: got %0d cycles required %0d", t_last - t_load, 44 + 10 * (int'(SB_LAT) + 1));
    end
`endif
  endtask

`ifdef MSKAES_KS_MULTISIZE_EN
  task automatic test_aes192();
    rk_ready = 1'b1;
    load_key(K192, 2'd1);
    drain(0, 99, 800);
    n_checks++;
    if (dut_w[6] !== 32'hfe0c91f7 || dut_w[51] !== 32'h01002202) begin
      n_err++; $display("FAIL aes192_spot: w6=%h w51=%h required fe0c91f7 01002202", dut_w[6], dut_w[51]);
    end
  endtask

  task automatic test_aes256();
    rk_ready = 1'b1;
    load_key(K256, 2'd2);
    drain(0, 99, 900);
    n_checks++;
    if (dut_w[8] !== 32'h9ba35411 || dut_w[12] !== 32'ha8b09c1a || dut_w[59] !== 32'h706c631e) begin
      n_err++;
      $display("FAIL aes256_spot: w8=%h w12=%h w59=%h required 9ba35411 a8b09c1a 706c631e",
               dut_w[8], dut_w[12], dut_w[59]);
    end
  endtask
`endif

  task automatic test_random_ready();
    rk_ready = 1'b0;
    load_key(K128, 2'd0);
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 8; j++) sh_key[j*WW +: WW] = reshare($urandom);
      in_valid = 1'b1;
      @(negedge clk);
      n_checks++;
      if (rk_valid !== 1'b1 || rk_idx !== 6'd0 || rec(sh_rk) !== 32'h2b7e1516) begin
        n_err++;
        $display("FAIL load_ignored: valid=%b idx=%0d w=%h, required 1 0 2b7e1516", rk_valid, rk_idx, rec(sh_rk));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain(1, 99, 4000);
  endtask

  task automatic test_reset_in_sbwait();
    rk_ready = 1'b1;
    load_key(K128, 2'd0);
    drain(0, 7, 300);
    @(negedge clk);
    n_checks++;
    if (sb_req !== 1'b1 || rk_valid !== 1'b0) begin
      n_err++; $display("FAIL sbwait_entry: sb_req=%b valid=%b, required 1 0", sb_req, rk_valid);
    end
    @(posedge clk); @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, rk_valid, sb_req, rk_last, rk_idx, sh_rk, sh_sb_out} !== {1'b1, 3'b000, 6'd0, {(2*WW){1'b0}}}) begin
      n_err++;
      $display("FAIL midrun_reset: ready=%b valid=%b req=%b last=%b idx=%0d rk=%h sbo=%h, required 1 0 0 0 0 0 0",
               in_ready, rk_valid, sb_req, rk_last, rk_idx, sh_rk, sh_sb_out);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    load_key(K128, 2'd0);
    drain(0, 99, 600);
  endtask

  task automatic test_back_to_back();
    logic [255:0] k;
    rk_ready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom, 128'h0};
      load_key(k, 2'd0);
      drain(0, 99, 600);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    init_sbox();
    test_reset();
    test_aes128();
    test_key_size_default();
`ifdef MSKAES_KS_MULTISIZE_EN
    test_aes192();
    test_aes256();
`endif
    test_random_ready();
    test_reset_in_sbwait();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/mskaes_32bits_key_sched_multi.md
# mskaes_32bits_key_sched_multi

Masked AES key-schedule engine generating round-key words one 32-bit column at a time for AES-128/192/256, in d-share Boolean masking. It has its own sequencing FSM, word counter and RCON register, and drives a shared fixed-latency masked Sbox over a request/return port. It is a successor to the 32-bit AES-128 key datapath, which depends on external control strobes; this block needs only a key-load handshake and a round-key output handshake.

## Interface
- d, 2: number of shares.
- SB_LAT, 4: fixed Sbox latency in cycles, request to result (≥1).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  key load request.
- in_ready  out  1  high only in IDLE.
- key_size  in  2  0=AES-128, 1=AES-192, 2=AES-256, 3=treated as 0; sampled at load.
- sh_key  in  256*d  shared key; words 0..Nk-1 used, 32*d bits per word, word 0 lowest.
- sh_sb_out  out  32*d  rotated/unrotated word to Sbox.
- sb_req  out  1  one-cycle Sbox request.
- sh_sb_in  in  32*d  Sbox result, valid exactly SB_LAT cycles after sb_req.
- rk_valid  out  1  sh_rk holds word w[i].
- rk_ready  in  1  consumer accepts word.
- sh_rk  out  32*d  round-key word, shared.
- rk_idx  out  6  index i of presented word.
- rk_last  out  1  high with final word (i = Nw-1).

## Operation
- Nk = 4/6/8; Nw = 44/52/60.
- FSM states: IDLE, EMIT, SB_WAIT.
- IDLE: in_ready=1. On in_valid: load Nk words into an 8-word shift register; latch Nk; set i=0 and rcon=0x01; go to EMIT.
- EMIT: rk_valid=1 and sh_rk=w[i]. When rk_valid && rk_ready:
  - If i = Nw-1, go to IDLE.
  - Else i++ and compute the next word.
- Next word, for i<Nk: taken directly from the loaded key.
- Next word, Sbox case (i mod Nk = 0, or Nk=8 and i mod 8 = 4):
  - Drive sh_sb_out = RotWord(w[i-1]) (rotation only in the first case); pulse sb_req; go to SB_WAIT.
  - On the SB_LAT-th cycle capture sh_sb_in, XOR rcon into byte 0 of share 0 (first case only), then XOR with w[i-Nk].
  - Advance rcon by xtime in the first case only. Return to EMIT.
- Next word, otherwise: w[i] = w[i-1] ^ w[i-Nk], computed share-wise, with no wait.
- Sbox is never requested while a request is outstanding.
- Only XOR, rotate and mux act on shares: no share recombination, no non-linear logic in the block.
- rk_ready low stalls indefinitely; sh_rk, rk_idx and rk_last are held.
- in_valid outside IDLE is ignored.

## Timing
- Reset values:
  - in_ready=1, rk_valid=0, sb_req=0, rk_last=0, rk_idx=0.
  - sh_rk=0, sh_sb_out=0, all key registers=0, state IDLE.
- Load accepted at edge T: rk_valid=1 with w[0] from T+1.
- Linear words: one per cycle under continuous rk_ready.
- Sbox words:
  - Acceptance of w[i-1] at edge E; sb_req high in cycle E+1.
  - Result captured at edge E+1+SB_LAT; w[i] valid from the following cycle.
  - Bubble of SB_LAT+1 cycles.
- Full AES-128 key, rk_ready tied high: 44 + 10·(SB_LAT+1) cycles after load.
- rst during EMIT or SB_WAIT: immediate return to reset values. A late Sbox result is ignored.
- rk_last deasserts with rk_valid after the final acceptance. The next load is possible in the cycle after that.

## Configuration
- MSKAES_KS_MULTISIZE_EN defined: all three key sizes supported, with an 8-word store.
- Not defined:
  - AES-128 only: key_size ignored, Nk fixed at 4, store is 4 words.
  - Only sh_key[128*d-1:0] used; upper bits unconnected.
  - Timing identical to the AES-128 case.

## Test plan
- Key 2b7e151628aed2a6abf7158809cf4f3c, fresh random shares each run, rk_ready=1 -> recombined w[4]=a0fafe17, w[43]=b6630ca6; rk_last only at idx 43; rk_valid high in the cycle after load.
- AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> w[6]=fe0c91f7, w[51]=01002202.
- AES-256 key 603deb10…0914dff4 -> w[8]=9ba35411, w[12] uses SubWord without rcon, w[59]=706c631e.
- Random rk_ready (≈30% duty) -> same word sequence as the continuous run; outputs stable while stalled.
- rst asserted while in SB_WAIT at i=8 -> all outputs at reset values; a fresh load of the same key reproduces w[0..43].
- Macro undefined, key_size=2 -> AES-128 sequence of 44 words only.
